heater_ctrl: RTL and testbench
==============================

// Module: heater_ctrl
// PURPOSE
//  Mode sequencer for the bath heater power stage: turns decoded key pulses into a mode state machine.
//  Drives the fan and the two heater stages with inrush staging, fan run-on after heated modes,
//  dry-mode auto-off and over-temperature shutdown. Exports mode and countdown to the display/animation logic.
// PARAMETERS
//  TICK_DIV   50_000_000  sys_clk cycles per 1 s tick (bench overrides small)
//  STAGE_CYC  1000        cycles between heater_lo and heater_hi on entry to HEAT
//  RUNON_AH   2           fan run-on seconds after AIR_HEAT or DRY (1..15)
//  RUNON_HT   4           fan run-on seconds after HEAT or over-temp (1..15)
//  DRY_S      15          DRY auto-off time in seconds (1..15)
// PORTS
//  sys_clk      in   1  system clock
//  rst          in   1  synchronous reset, active-high
//  key_air      in   1  1-cycle pulse, AIR key (debounced upstream)
//  key_airheat  in   1  1-cycle pulse, AIR_HEAT key
//  key_heat     in   1  1-cycle pulse, HEAT key
//  key_dry      in   1  1-cycle pulse, DRY key
//  key_light    in   1  1-cycle pulse, toggle lamp
//  overtemp     in   1  level, thermal cut-out request
//  mode         out  3  0 AIR, 1 AIR_HEAT, 2 HEAT, 3 DRY, 4 STANDBY
//  fan_on       out  1  fan relay
//  heater_lo    out  1  heater stage 1
//  heater_hi    out  1  heater stage 2
//  light        out  1  lamp
//  cd_active    out  1  run-on or dry countdown running
//  cd_sec       out  4  remaining seconds of active countdown, else 0
// BEHAVIOUR
//  - All outputs registered. Key sampled at edge N -> outputs change at edge N+1.
//  - Reset (any cycle, mid-countdown included): mode=4, light=0, all other outputs 0.
//    Prescaler and counters are cleared.
//  - States: STANDBY, AIR, AIR_HEAT, HEAT, DRY, RUNON.
//  - Valid mode key: exactly one of the four mode keys high. Zero or >=2 high: no mode change.
//  - Actuators:
//      STANDBY  all off
//      AIR      fan
//      AIR_HEAT fan + lo
//      HEAT     fan + lo + hi (staged)
//      DRY      fan + lo
//      RUNON    fan only
//  - Key for a mode different from the current one: go to that mode directly, including heated->heated.
//    Heaters follow the new mode, with no run-on.
//  - Key equal to current mode (toggle off):
//      AIR             -> STANDBY
//      AIR_HEAT / DRY  -> RUNON, load RUNON_AH
//      HEAT            -> RUNON, load RUNON_HT
//  - RUNON: mode output holds the mode being left. cd_active=1, cd_sec=remaining.
//    On each tick with cd_sec>1, decrement. Tick with cd_sec==1 -> STANDBY next edge, cd_sec=0.
//  - Any valid mode key during RUNON: abort run-on, enter the keyed mode (even if it is the mode being left).
//  - DRY entry loads cd_sec=DRY_S, cd_active=1, and counts down as above.
//    Expiry -> RUNON with RUNON_AH. Leaving DRY by another key clears the dry count.
//  - Prescaler restarts at 0 on every countdown load, so the first second is a full TICK_DIV cycles.
//    Tick = prescaler reaching TICK_DIV-1.
//  - HEAT staging: heater_hi rises exactly STAGE_CYC cycles after heater_lo is high in HEAT.
//    Entering from AIR_HEAT/DRY (lo already on): staging counter starts on entry.
//    heater_hi drops on the same edge that heater_lo drops or HEAT is left.
//  - overtemp high (sampled edge N): at N+1 heater_lo=heater_hi=0.
//    If the state was AIR_HEAT/HEAT/DRY -> RUNON with RUNON_HT; mode output holds the mode being left.
//    While overtemp is high, AIR_HEAT/HEAT/DRY keys are ignored; AIR key and toggles to STANDBY are honoured.
//  - overtemp high during RUNON: no reload; the countdown continues.
//  - Light: key_light toggles light at the next edge, independent of mode keys in the same cycle.
//    light is unaffected by overtemp.
//  - Invariant: heater_lo or heater_hi => fan_on; heater_hi => heater_lo. Never violated, not even for one cycle.
//  - cd_sec is 4-bit unsigned. Parameters >15 are illegal (elaboration check).
// TESTING  (TICK_DIV=4, STAGE_CYC=3, RUNON_AH=2, RUNON_HT=4, DRY_S=3)
//  1 reset, key_heat pulse
//      -> mode=2, fan=1, lo=1 at +1; hi=1 at +4.
//    key_heat again
//      -> lo=hi=0, fan=1, cd_sec=4, then 3,2,1 every 4 cycles, STANDBY (mode=4, fan=0) 16 cycles after the key.
//  2 key_dry
//      -> cd_sec=3, expiry after 12 cycles -> RUNON with cd_sec=2, STANDBY after a further 8 cycles.
//  3 AIR_HEAT, then key_heat
//      -> no run-on, hi rises 3 cycles later.
//    Then key_air
//      -> lo=hi=0, fan=1, mode=0, cd_active=0.
//  4 HEAT, overtemp=1
//      -> next edge lo=hi=0, RUNON cd_sec=4.
//    key_heat during overtemp
//      -> ignored. key_air -> mode=0.
//  5 key_air and key_heat in the same cycle
//      -> no change. key_light together with key_dry -> light toggles and DRY entered.
//  6 rst asserted mid-RUNON (cd_sec=2)
//      -> next edge all outputs at reset values. Assert the fan/heater invariant every cycle in all tests.

Source files
------------

// File: rtl/heater_ctrl.sv
// Bath heater mode sequencer: key pulses -> fan/heater drive with staging, run-on, dry timeout, over-temp cut.
// One-cycle latency from any sampled input to its registered outputs; there is no backpressure.
module heater_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int STAGE_CYC = 1000,
  parameter int RUNON_AH  = 2,
  parameter int RUNON_HT  = 4,
  parameter int DRY_S     = 15
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       key_air,
  input  logic       key_airheat,
  input  logic       key_heat,
  input  logic       key_dry,
  input  logic       key_light,
  input  logic       overtemp,
  output logic [2:0] mode,
  output logic       fan_on,
  output logic       heater_lo,
  output logic       heater_hi,
  output logic       light,
  output logic       cd_active,
  output logic [3:0] cd_sec
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (STAGE_CYC > 1) ? $clog2(STAGE_CYC) : 1;
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STG_MAX  = SW'(STAGE_CYC - 1);
  localparam logic [3:0]    CD_AH    = 4'(RUNON_AH);
  localparam logic [3:0]    CD_HT    = 4'(RUNON_HT);
  localparam logic [3:0]    CD_DRY   = 4'(DRY_S);

  generate
    if (TICK_DIV < 1 || STAGE_CYC < 1 || RUNON_AH < 1 || RUNON_AH > 15 ||
        RUNON_HT < 1 || RUNON_HT > 15 || DRY_S < 1 || DRY_S > 15) begin : g_param_check
      $error("heater_ctrl: illegal parameter value");
    end
  endgenerate

  // Encodings of the four user modes equal their mode output codes.
  typedef enum logic [2:0] {
    S_AIR     = 3'd0,
    S_AIRHEAT = 3'd1,
    S_HEAT    = 3'd2,
    S_DRY     = 3'd3,
    S_STANDBY = 3'd4,
    S_RUNON   = 3'd5
  } state_t;

  state_t        state, nstate;
  logic [2:0]    left_mode, nleft;
  logic [3:0]    cd, ncd;
  logic [PW-1:0] presc, npresc;
  logic [SW-1:0] stg, nstg;
  logic [2:0]    kmode;
  logic          key_valid, take_key, cur_heated, tick, hi_nxt;

  always_comb begin
    nstate     = state;
    nleft      = left_mode;
    ncd        = cd;
    npresc     = presc;
    nstg       = '0;
    hi_nxt     = 1'b0;
    kmode      = 3'd0;
    if (key_airheat) kmode = 3'd1;
    if (key_heat)    kmode = 3'd2;
    if (key_dry)     kmode = 3'd3;
    key_valid  = $onehot({key_air, key_airheat, key_heat, key_dry});
    take_key   = key_valid && !(overtemp && !key_air);
    cur_heated = (state == S_AIRHEAT) || (state == S_HEAT) || (state == S_DRY);
    tick       = ((state == S_DRY) || (state == S_RUNON)) && (presc == TICK_MAX);

    if ((state == S_DRY) || (state == S_RUNON))
      npresc = tick ? '0 : presc + 1'b1;

    if (take_key) begin
      npresc = '0;
      if (kmode == 3'(state)) begin
        nleft = 3'(state);
        case (state)
          S_AIR:             begin nstate = S_STANDBY; ncd = 4'd0;  end
          S_HEAT:            begin nstate = S_RUNON;   ncd = CD_HT; end
          default:           begin nstate = S_RUNON;   ncd = CD_AH; end
        endcase
      end else begin
        nstate = state_t'(kmode);
        ncd    = (kmode == 3'd3) ? CD_DRY : 4'd0;
      end
    end else if (overtemp && cur_heated) begin
      nstate = S_RUNON;
      nleft  = 3'(state);
      ncd    = CD_HT;
      npresc = '0;
    end else if (tick) begin
      if (cd > 4'd1) begin
        ncd = cd - 4'd1;
      end else if (state == S_DRY) begin
        nstate = S_RUNON;
        nleft  = 3'(S_DRY);
        ncd    = CD_AH;
      end else begin
        nstate = S_STANDBY;
        ncd    = 4'd0;
      end
    end

    // Staging only advances while HEAT persists; any fresh entry restarts it.
    if ((nstate == S_HEAT) && (state == S_HEAT)) begin
      nstg   = (stg == STG_MAX) ? stg : stg + 1'b1;
      hi_nxt = heater_hi || (stg == STG_MAX);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= S_STANDBY;
      left_mode <= 3'd4;
      cd        <= 4'd0;
      presc     <= '0;
      stg       <= '0;
    end else begin
      state     <= nstate;
      left_mode <= nleft;
      cd        <= ncd;
      presc     <= npresc;
      stg       <= nstg;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      mode      <= 3'd4;
      fan_on    <= 1'b0;
      heater_lo <= 1'b0;
      heater_hi <= 1'b0;
      light     <= 1'b0;
      cd_active <= 1'b0;
    end else begin
      mode      <= (nstate == S_RUNON) ? nleft : 3'(nstate);
      fan_on    <= (nstate != S_STANDBY);
      heater_lo <= (nstate == S_AIRHEAT) || (nstate == S_HEAT) || (nstate == S_DRY);
      heater_hi <= hi_nxt;
      light     <= light ^ key_light;
      cd_active <= (nstate == S_DRY) || (nstate == S_RUNON);
    end
  end

  assign cd_sec = cd;

endmodule

// File: tb/tb_heater_ctrl.sv
// Directed table-driven bench for heater_ctrl with small timing parameters.
module tb_heater_ctrl;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_air = 1'b0, key_airheat = 1'b0, key_heat = 1'b0, key_dry = 1'b0, key_light = 1'b0;
  logic       overtemp = 1'b0;
  logic [2:0] mode;
  logic       fan_on, heater_lo, heater_hi, light, cd_active;
  logic [3:0] cd_sec;

  heater_ctrl #(
    .TICK_DIV(4), .STAGE_CYC(3), .RUNON_AH(2), .RUNON_HT(4), .DRY_S(3)
  ) dut (
    .sys_clk(sys_clk), .rst(rst),
    .key_air(key_air), .key_airheat(key_airheat), .key_heat(key_heat),
    .key_dry(key_dry), .key_light(key_light), .overtemp(overtemp),
    .mode(mode), .fan_on(fan_on), .heater_lo(heater_lo), .heater_hi(heater_hi),
    .light(light), .cd_active(cd_active), .cd_sec(cd_sec)
  );

  always #5 sys_clk = ~sys_clk;

  localparam logic [4:0] K0  = 5'b00000;
  localparam logic [4:0] KA  = 5'b00001;
  localparam logic [4:0] KAH = 5'b00010;
  localparam logic [4:0] KH  = 5'b00100;
  localparam logic [4:0] KD  = 5'b01000;
  localparam logic [4:0] KL  = 5'b10000;

  typedef struct {
    logic        rst;
    logic        ot;
    logic [4:0]  keys;
    int          n;
    logic [11:0] exp;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  vec_t vecs[$];

  wire [11:0] outs = {mode, fan_on, heater_lo, heater_hi, light, cd_active, cd_sec};

  function automatic vec_t mk(input logic r, input logic o, input logic [4:0] k, input int n,
                              input logic [2:0] m, input logic f, input logic l, input logic h,
                              input logic lt, input logic ca, input logic [3:0] c);
    vec_t v;
    v.rst = r; v.ot = o; v.keys = k; v.n = n;
    v.exp = {m, f, l, h, lt, ca, c};
    return v;
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got mode=%0d fan=%b lo=%b hi=%b light=%b cda=%b cd=%0d, expected mode=%0d fan=%b lo=%b hi=%b light=%b cda=%b cd=%0d",
               name, got[11:9], got[8], got[7], got[6], got[5], got[4], got[3:0],
               exp[11:9], exp[8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic step(input logic [4:0] k, input logic o, input logic r);
    @(negedge sys_clk);
    {key_light, key_dry, key_heat, key_airheat, key_air} = k;
    overtemp = o;
    rst = r;
    @(posedge sys_clk);
    #1;
    {key_light, key_dry, key_heat, key_airheat, key_air} = K0;
  endtask

  // Fan must cover any heater stage, and stage 2 requires stage 1, on every cycle.
  always @(negedge sys_clk) begin
    if (mon_en) begin
      total++;
      if (((heater_lo || heater_hi) && !fan_on) || (heater_hi && !heater_lo)) begin
        bad++;
        $display("FAIL invariant: fan=%b lo=%b hi=%b, required lo|hi => fan and hi => lo",
                 fan_on, heater_lo, heater_hi);
      end
    end
  end

  initial begin
    int cyc;
    // rst, ot, keys, n | mode fan lo hi light cda cd  (expectation holds on each of the n edges)
    vecs.push_back(mk(1, 0, K0,       2, 4, 0, 0, 0, 0, 0, 0));
    // heat on, staged hi, toggle off through 4 s run-on
    vecs.push_back(mk(0, 0, KH,       3, 2, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, K0,       2, 2, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, KH,       4, 2, 1, 0, 0, 0, 1, 4));
    vecs.push_back(mk(0, 0, K0,       4, 2, 1, 0, 0, 0, 1, 3));
    vecs.push_back(mk(0, 0, K0,       4, 2, 1, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, K0,       4, 2, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, K0,       2, 4, 0, 0, 0, 0, 0, 0));
    // dry expiry into run-on
    vecs.push_back(mk(0, 0, KD,       4, 3, 1, 1, 0, 0, 1, 3));
    vecs.push_back(mk(0, 0, K0,       4, 3, 1, 1, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, K0,       4, 3, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, K0,       4, 3, 1, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, K0,       4, 3, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, K0,       2, 4, 0, 0, 0, 0, 0, 0));
    // heated -> heated without run-on, then air
    vecs.push_back(mk(0, 0, KAH,      2, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, KH,       3, 2, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, K0,       1, 2, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, KA,       2, 0, 1, 0, 0, 0, 0, 0));
    // over-temperature
    vecs.push_back(mk(0, 0, KH,       3, 2, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, K0,       1, 2, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, K0,       4, 2, 1, 0, 0, 0, 1, 4));
    vecs.push_back(mk(0, 1, KH,       1, 2, 1, 0, 0, 0, 1, 3));
    vecs.push_back(mk(0, 1, KA,       2, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, KAH,      2, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, KA,       1, 4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, K0,       1, 4, 0, 0, 0, 0, 0, 0));
    // invalid key combos, light alongside a mode key, assorted transitions
    vecs.push_back(mk(0, 0, KA | KH,  2, 4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, KL | KD,  2, 3, 1, 1, 0, 1, 1, 3));
    vecs.push_back(mk(0, 0, KA,       1, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, KL,       1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, KAH,      1, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, KD,       1, 3, 1, 1, 0, 0, 1, 3));
    vecs.push_back(mk(0, 0, KD,       4, 3, 1, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, KD,       1, 3, 1, 1, 0, 0, 1, 3));
    vecs.push_back(mk(0, 0, KH,       3, 2, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, K0,       1, 2, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, KAH,      1, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, KAH,      2, 1, 1, 0, 0, 0, 1, 2));
    vecs.push_back(mk(1, 0, K0,       1, 4, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, K0,       3, 4, 0, 0, 0, 0, 0, 0));
    // over-temperature out of DRY, then dry key aborts the run-on
    vecs.push_back(mk(0, 0, KD,       1, 3, 1, 1, 0, 0, 1, 3));
    vecs.push_back(mk(0, 1, K0,       2, 3, 1, 0, 0, 0, 1, 4));
    vecs.push_back(mk(0, 0, KD,       1, 3, 1, 1, 0, 0, 1, 3));
    vecs.push_back(mk(0, 0, KA,       1, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, KA,       1, 4, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        step((c == 0) ? vecs[i].keys : K0, vecs[i].ot, vecs[i].rst);
        chk($sformatf("vec%0d.%0d", i, c), outs, vecs[i].exp);
      end
      mon_en = 1'b1;
    end

    // Reset in the middle of a heat run-on with the lamp on.
    step(KL, 0, 0);
    step(KH, 0, 0);
    step(KH, 0, 0);
    repeat (8) step(K0, 0, 0);
    chk("runon_mid", outs, {3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2});
    step(K0, 0, 1);
    chk("rst_mid_runon", outs, {3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
    step(K0, 0, 0);
    chk("after_rst", outs, {3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});

    // Whole dry cycle length: 3 s dry + 2 s run-on at 4 cycles per second.
    step(KD, 0, 0);
    chk("dry_entry", outs, {3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3});
    cyc = 0;
    while (mode != 3'd4 && cyc < 40) begin
      step(K0, 0, 0);
      cyc++;
    end
    total++;
    if (cyc != 20) begin
      bad++;
      $display("FAIL dry_total: got %0d cycles to standby, expected 20", cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
